// File: rtl/vga_timing_out.sv
// 640x480@60 VGA raster timing: pixel/line counters, frame strobe and counter,
// and a registered 8-bit pin word carrying syncs plus blank-gated 2-bit colour.
module vga_timing_out #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic [5:0] rgb_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       display_on,
   output logic       next_frame,
   output logic [7:0] frame_count,
   output logic [7:0] vga_out
);

   localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   localparam logic [7:0] PINS_IDLE = 8'b1000_1000;

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic [7:0] frame_q, frame_d;
   logic [7:0] vga_q, vga_d;

   logic       h_last, v_last;
   logic       hsync, vsync;
   logic [5:0] rgb_m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
         vga_q   <= PINS_IDLE;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         vga_q   <= vga_d;
      end
   end

   // >= rather than == so a corrupted counter still falls back into range
   assign h_last = (h_q >= H_LAST);
   assign v_last = (v_q >= V_LAST);

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_en) begin
         if (h_last) begin
            h_d = '0;
            v_d = v_last ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   assign next_frame = pix_en && (h_q == 10'd0) && (v_q == V_VIS);

   always_comb begin
      frame_d = frame_q;
      if (next_frame) frame_d = frame_q + 8'd1;
   end

   assign display_on = (h_q < H_VIS) && (v_q < V_VIS);
   assign hsync      = !((h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI));
   assign vsync      = !((v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI));
   assign rgb_m      = display_on ? rgb_in : 6'd0;

   // rgb_in is {R1,R0,G1,G0,B1,B0}; pins want LSBs in the upper nibble
   always_comb begin
      vga_d = {hsync, rgb_m[0], rgb_m[2], rgb_m[4],
               vsync, rgb_m[1], rgb_m[3], rgb_m[5]};
   end

   assign x           = h_q;
   assign y           = v_q;
   assign frame_count = frame_q;
   assign vga_out     = vga_q;

endmodule

// File: doc/vga_timing_out.md
VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 clk  input  1  pixel clock, 25.175 MHz nominal; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 pix_en  input  1  pixel-advance qualifier; tie high for one pixel per clk.
REQ-004 rgb_in  input  6  colour from the selected pattern generator, {R[1:0],G[1:0],B[1:0]}, combinational from x/y.
REQ-005 x  output  10  current horizontal pixel count, 0..799.
REQ-006 y  output  10  current vertical line count, 0..524.
REQ-007 display_on  output  1  high when x<640 and y<480.
REQ-008 next_frame  output  1  single-cycle frame strobe consumed by pattern generators.
REQ-009 frame_count  output  8  free-running frame counter.
REQ-010 vga_out  output  8  registered pin word {hsync,B[0],G[0],R[0],vsync,B[1],G[1],R[1]}.

Function
REQ-011 Horizontal counter h shall advance by 1 on each clk with pix_en=1, and wrap 799->0.
REQ-012 Vertical counter v shall advance by 1 only when h wraps, and wrap 524->0.
REQ-013 When pix_en=0, h, v, frame_count and next_frame shall hold or stay low, with no advance.
REQ-014 x=h and y=v shall be driven directly from the counters, with zero latency.
REQ-015 display_on shall be combinational from h and v, with zero latency.
REQ-016 Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-017 Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-018 hsync shall be active-low, 0 exactly when 656<=h<=751.
REQ-019 vsync shall be active-low, 0 exactly when 490<=v<=491.
REQ-020 next_frame shall be 1 exactly when pix_en=1, h=0 and v=480 (start of vertical blank); one clk wide per frame.
REQ-021 frame_count shall increment by 1 mod 256 on the same clk edge on which next_frame=1.
REQ-022 vga_out shall register every clk (independent of pix_en): sync bits from current h/v, colour bits = rgb_in when display_on else 0.
REQ-023 Latency: vga_out reflects the h/v/rgb_in present one clk earlier, so sync and colour stay aligned.
REQ-024 Colour bits shall never be non-zero in vga_out when the sampled position was in blanking, whatever rgb_in is.
REQ-025 Counter widths shall be exactly 10 bits; no out-of-range h>799 or v>524 shall ever occur.

Reset
REQ-026 While rst_n=0: h=0, v=0, frame_count=0, vga_out=8'b1000_1000 (syncs inactive, colour off).
REQ-027 Reset shall take effect immediately on rst_n falling, regardless of clk.
REQ-028 Reset asserted mid-frame shall abandon the frame; no next_frame pulse shall be generated by the reset itself.
REQ-029 After rst_n rises, the first pix_en clk shall move h 0->1.
REQ-030 next_frame shall first fire when v reaches 480.

Verification
REQ-031 Reset then pix_en=1, rgb_in=6'b111111 -> vga_out=8'b1111_1111 one clk after (h,v)=(0,0); vga_out=8'b1000_1000 one clk after h=640.
REQ-032 Count one line -> hsync low for exactly 96 clks starting one clk after h=656; line period 800 clks.
REQ-033 Run full frame -> vsync low for exactly 1600 clks (lines 490-491); frame period 420000 clks; next_frame one pulse at (0,480); frame_count 0->1.
REQ-034 pix_en toggled 1,0,1,0 -> h advances every other clk; next_frame still exactly one clk wide; vga_out keeps registering each clk.
REQ-035 Assert rst_n=0 at (h,v)=(300,200) between edges -> outputs reset asynchronously to REQ-026 values; no next_frame; restart from (0,0).
REQ-036 Run 256 frames -> frame_count wraps 255->0 at the 256th next_frame.
